add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_pkg.sv | 12 +
 rtl/add_arbiter_part2.sv | 10 +
 rtl/add_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared constants for the round-robin add arbiter: adder width, default
// requester count and the requester-id width helper.
package add_arbiter_pkg;

  localparam int W_ADD     = 8;
  localparam int N_REQ_DEF = 4;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_arbiter_part2.sv
// The existing shared combinational adder: O = (A + B) mod 256.
module part2 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] o
);

  assign o = a + b;

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one 8-bit adder among N_REQ requesters, with a
// single registered response slot (sum, carry-out, requester id).
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_ADD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W-1:0]         req_a,
  input  logic [N_REQ*W-1:0]         req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [W-1:0]               rsp_sum,
  output logic                       rsp_ovf,
  output logic [id_width(N_REQ)-1:0] rsp_id
);

  localparam int IDW = id_width(N_REQ);

  logic [IDW-1:0] ptr_r;
  logic [IDW:0]   pick_s;
  logic [IDW-1:0] grant_s;
  logic [IDW-1:0] nxt_ptr_s;
  logic           free_s;
  logic           xfer_s;
  logic [W-1:0]   a_mux_s;
  logic [W-1:0]   b_mux_s;
  logic [W-1:0]   sum_s;
  logic           ovf_s;

  // Returns {found, index} of the first valid requester at or after p, wrapping.
  // Scanning downward lets the closest hit to p overwrite the farther ones.
  function automatic logic [IDW:0] pick(input logic [N_REQ-1:0] v,
                                        input logic [IDW-1:0]   p);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(p) + k) % N_REQ);
      if (v[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Grant selection, operand mux and carry-out of the shared adder.
  always_comb begin
    pick_s    = pick(req_valid, ptr_r);
    grant_s   = pick_s[IDW-1:0];
    free_s    = !rsp_valid || rsp_ready;
    xfer_s    = free_s && pick_s[IDW] && !rst;
    req_ready = '0;
    if (xfer_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
    a_mux_s   = req_a[int'(grant_s)*W +: W];
    b_mux_s   = req_b[int'(grant_s)*W +: W];
    ovf_s     = (a_mux_s[W-1] & b_mux_s[W-1]) |
                ((a_mux_s[W-1] ^ b_mux_s[W-1]) & ~sum_s[W-1]);
    nxt_ptr_s = IDW'((int'(grant_s) + 1) % N_REQ);
  end

  part2 u_adder (
    .a (a_mux_s),
    .b (b_mux_s),
    .o (sum_s)
  );

  // Response slot and round-robin pointer; a transfer overwrites any slot being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_ovf   <= 1'b0;
      rsp_id    <= '0;
      ptr_r     <= '0;
    end else if (xfer_s) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= sum_s;
      rsp_ovf   <= ovf_s;
      rsp_id    <= grant_s;
      ptr_r     <= nxt_ptr_s;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
